// File: rtl/ddr3_ui_responder.sv
// rtl/ddr3_ui_responder.sv - DDR3 user-interface responder backed by an on-chip 256-bit array
// Refresh-stall emulation is enabled by defining DDR3_RESP_REFRESH_STALL_EN.
module ddr3_ui_responder #(
   parameter int MEM_WORDS_LOG2 = 10,
   parameter int RD_LATENCY     = 4,
   parameter int CALIB_CYCLES   = 16,
   parameter int REF_PERIOD     = 64,
   parameter int REF_STALL      = 8
) (
   input  logic         clk,
   input  logic         ddr_rst,
   input  logic         cmd_en,
   input  logic [2:0]   cmd,
   input  logic [28:0]  addr,
   output logic         cmd_ready,
   input  logic         wr_data_en,
   input  logic [255:0] wr_data,
   input  logic         wr_data_end,
   input  logic [31:0]  wr_data_mask,
   output logic         wr_data_rdy,
   output logic [255:0] rd_data,
   output logic         rd_data_valid,
   output logic         rd_data_end,
   output logic         init_calib_complete,
   output logic         proto_err
);
   localparam int          DEPTH      = 1 << MEM_WORDS_LOG2;
   localparam logic [15:0] CALIB_LAST = 16'(CALIB_CYCLES - 1);
   localparam logic [3:0]  RD_INIT    = 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {CALIB, IDLE, RD_WAIT, WR_DATA} state_t;

   state_t                    state_q, state_d;
   logic [15:0]               calib_cnt_q, calib_cnt_d;
   logic                      calib_q, calib_d;
   logic [3:0]                rd_cnt_q, rd_cnt_d;
   logic [MEM_WORDS_LOG2-1:0] rd_idx_q, rd_idx_d;
   logic [MEM_WORDS_LOG2-1:0] wr_idx_q, wr_idx_d;
   logic                      buf_full_q, buf_full_d;
   logic [255:0]              buf_data_q, buf_data_d;
   logic [31:0]               buf_mask_q, buf_mask_d;
   logic                      err_q, err_d;
   logic                      rd_valid_q, rd_valid_d;
   logic [255:0]              rd_data_q, rd_data_d;

   logic [255:0]              mem_q [DEPTH];
   logic                      mem_we;
   logic [MEM_WORDS_LOG2-1:0] mem_widx;
   logic [255:0]              mem_wdata;
   logic [31:0]               mem_wmask;
   logic [MEM_WORDS_LOG2-1:0] rd_sel;
   logic                      rd_fire;
   logic                      beat_direct;
   logic                      stall;
   logic                      cmd_acc;
   logic                      beat_acc;
   logic [MEM_WORDS_LOG2-1:0] cmd_idx;
   logic                      unused_bits;

   assign cmd_idx             = addr[MEM_WORDS_LOG2+2:3];
   assign cmd_ready           = (state_q == IDLE) && !stall;
   assign wr_data_rdy         = !buf_full_q && calib_q && !stall;
   assign cmd_acc             = cmd_en && cmd_ready;
   assign beat_acc            = wr_data_en && wr_data_rdy;
   assign rd_data             = rd_data_q;
   assign rd_data_valid       = rd_valid_q;
   assign rd_data_end         = rd_valid_q;
   assign init_calib_complete = calib_q;
   assign proto_err           = err_q;

`ifdef DDR3_RESP_REFRESH_STALL_EN
   localparam logic [15:0] REF_LAST = 16'(REF_PERIOD - 1);
   localparam logic [15:0] REF_ON   = 16'(REF_PERIOD - REF_STALL);
   logic [15:0] ref_cnt_q;

   // Stall window sits at the tail of each period, so the first REF_PERIOD-REF_STALL cycles are usable.
   always_ff @(posedge clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         ref_cnt_q <= '0;
      end else if (calib_q) begin
         ref_cnt_q <= (ref_cnt_q == REF_LAST) ? '0 : ref_cnt_q + 16'd1;
      end
   end

   assign stall       = calib_q && (ref_cnt_q >= REF_ON);
   assign unused_bits = ^{addr[2:0], addr[28:MEM_WORDS_LOG2+3]};
`else
   assign stall       = 1'b0;
   assign unused_bits = ^{addr[2:0], addr[28:MEM_WORDS_LOG2+3], ((REF_PERIOD + REF_STALL) != 0)};
`endif

   always_comb begin
      state_d     = state_q;
      calib_cnt_d = calib_cnt_q;
      calib_d     = calib_q;
      rd_cnt_d    = rd_cnt_q;
      rd_idx_d    = rd_idx_q;
      wr_idx_d    = wr_idx_q;
      buf_full_d  = buf_full_q;
      buf_data_d  = buf_data_q;
      buf_mask_d  = buf_mask_q;
      err_d       = err_q;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
      mem_we      = 1'b0;
      mem_widx    = wr_idx_q;
      mem_wdata   = wr_data;
      mem_wmask   = wr_data_mask;
      rd_sel      = rd_idx_q;
      rd_fire     = 1'b0;
      beat_direct = 1'b0;

      if (beat_acc && !wr_data_end) begin
         err_d = 1'b1;
      end

      case (state_q)
         CALIB: begin
            if (calib_cnt_q == CALIB_LAST) begin
               state_d = IDLE;
               calib_d = 1'b1;
            end else begin
               calib_cnt_d = calib_cnt_q + 16'd1;
            end
         end
         IDLE: begin
            if (cmd_acc) begin
               if (cmd == 3'd1) begin
                  rd_idx_d = cmd_idx;
                  rd_cnt_d = RD_INIT;
                  state_d  = RD_WAIT;
                  if (RD_LATENCY == 1) begin
                     rd_fire = 1'b1;
                     rd_sel  = cmd_idx;
                  end
               end else if (cmd == 3'd0) begin
                  mem_widx = cmd_idx;
                  if (buf_full_q) begin
                     mem_we     = 1'b1;
                     mem_wdata  = buf_data_q;
                     mem_wmask  = buf_mask_q;
                     buf_full_d = 1'b0;
                  end else if (beat_acc) begin
                     mem_we      = 1'b1;
                     beat_direct = 1'b1;
                  end else begin
                     wr_idx_d = cmd_idx;
                     state_d  = WR_DATA;
                  end
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RD_WAIT: begin
            // rd_cnt_q reaching zero marks the cycle the beat is on the bus.
            if (rd_cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               rd_cnt_d = rd_cnt_q - 4'd1;
               if (rd_cnt_q == 4'd1) begin
                  rd_fire = 1'b1;
               end
            end
         end
         WR_DATA: begin
            if (beat_acc) begin
               mem_we      = 1'b1;
               beat_direct = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = CALIB;
      endcase

      if (beat_acc && !beat_direct) begin
         buf_full_d = 1'b1;
         buf_data_d = wr_data;
         buf_mask_d = wr_data_mask;
      end

      if (rd_fire) begin
         rd_valid_d = 1'b1;
         rd_data_d  = mem_q[rd_sel];
      end
   end

   always_ff @(posedge clk or posedge ddr_rst) begin
      if (ddr_rst) begin
         state_q     <= CALIB;
         calib_cnt_q <= '0;
         calib_q     <= 1'b0;
         rd_cnt_q    <= '0;
         rd_idx_q    <= '0;
         wr_idx_q    <= '0;
         buf_full_q  <= 1'b0;
         buf_data_q  <= '0;
         buf_mask_q  <= '0;
         err_q       <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         calib_cnt_q <= calib_cnt_d;
         calib_q     <= calib_d;
         rd_cnt_q    <= rd_cnt_d;
         rd_idx_q    <= rd_idx_d;
         wr_idx_q    <= wr_idx_d;
         buf_full_q  <= buf_full_d;
         buf_data_q  <= buf_data_d;
         buf_mask_q  <= buf_mask_d;
         err_q       <= err_d;
         rd_valid_q  <= rd_valid_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Backing store survives reset so data written before a reset reads back afterwards.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 32; b++) begin
            if (!mem_wmask[b]) begin
               mem_q[mem_widx][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end
         end
      end
   end
endmodule
